// File: rtl/pbutton_pkg.sv
// Shared types and constants for the push-button event decoder.
package pbutton_pkg;

  // Decoder states, binary encoded.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    WAIT_GAP = 3'd2,
    SECOND   = 3'd3,
    HELD     = 3'd4
  } state_t;

  // 32-bit cycle-count constants.
  localparam logic [31:0] CNT_ZERO = 32'd0;
  localparam logic [31:0] CNT_ONE  = 32'd1;
  localparam logic [31:0] CNT_TWO  = 32'd2;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // Threshold inputs of 0 behave as 1.
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    if (v == CNT_ZERO) begin
      at_least_one = CNT_ONE;
    end else begin
      at_least_one = v;
    end
  endfunction

endpackage

// File: rtl/pbutton_event_decoder_if.sv
// Bus between the debouncer / board test logic and the event decoder.
// count_load / count_load_value preload event_count for board bring-up.
interface pbutton_event_decoder_if #(
  parameter int REPEAT_W = 32
);
  logic                PB_state_pushed;
  logic                PB_state_released;
  logic [31:0]         long_press_cycles;
  logic [31:0]         dbl_gap_cycles;
  logic [REPEAT_W-1:0] repeat_cycles;
  logic                count_load;
  logic [15:0]         count_load_value;
  logic                EV_click;
  logic                EV_double_click;
  logic                EV_long_press;
  logic                EV_repeat;
  logic [15:0]         event_count;

  // Side that supplies button pulses and thresholds.
  modport master (
    output PB_state_pushed, PB_state_released,
    output long_press_cycles, dbl_gap_cycles, repeat_cycles,
    output count_load, count_load_value,
    input  EV_click, EV_double_click, EV_long_press, EV_repeat, event_count
  );

  // The decoder itself.
  modport slave (
    input  PB_state_pushed, PB_state_released,
    input  long_press_cycles, dbl_gap_cycles, repeat_cycles,
    input  count_load, count_load_value,
    output EV_click, EV_double_click, EV_long_press, EV_repeat, event_count
  );
endinterface

// File: rtl/pbutton_event_timer.sv
// Clear/enable saturating up-counter with an equality-compare flag.
module pbutton_event_timer #(
  parameter int           W   = 32,
  parameter logic [W-1:0] SAT = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         hit
);
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count register: clear has priority, increment stops at the saturation value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO;
    end else if (clr) begin
      count_r <= ZERO;
    end else if (en && (count_r != SAT)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == target);

endmodule

// File: rtl/pbutton_event_decoder.sv
// Push-button event decoder: turns debounced pushed/released pulses into
// one-cycle click, double-click, long-press and auto-repeat events.
// Optional feature macro: PBUTTON_AUTOREPEAT_EN (auto-repeat while held).
// Every event output is registered, so each decision is taken one cycle
// before the pulse is visible; the compare targets are chosen accordingly.
module pbutton_event_decoder
  import pbutton_pkg::*;
#(
  parameter int REPEAT_W = 32
) (
  input logic                    CLOCK_50,
  input logic                    RESET,
  pbutton_event_decoder_if.slave bus
);

  state_t      state_r;
  state_t      state_next_s;
  logic        pushed_s;
  logic        released_s;
  logic [31:0] long_len_s;
  logic [31:0] gap_s;
  logic [31:0] cnt_target_s;
  logic        long_is_one_s;
  logic        gap_is_zero_s;
  logic        cnt_en_s;
  logic        cnt_clr_s;
  logic        cnt_hit_s;
  logic        rpt_hit_s;
  logic        ev_click_s;
  logic        ev_double_s;
  logic        ev_long_s;
  logic        ev_repeat_s;
  logic        ev_click_r;
  logic        ev_double_r;
  logic        ev_long_r;
  logic        ev_repeat_r;
  logic [15:0] event_count_r;

  // A simultaneous push and release cancel each other out.
  assign pushed_s      = bus.PB_state_pushed & ~bus.PB_state_released;
  assign released_s    = bus.PB_state_released & ~bus.PB_state_pushed;
  assign long_len_s    = at_least_one(bus.long_press_cycles);
  assign gap_s         = bus.dbl_gap_cycles;
  assign long_is_one_s = (long_len_s == CNT_ONE);
  assign gap_is_zero_s = (gap_s == CNT_ZERO);
  assign cnt_en_s      = (state_r == PRESSED) || (state_r == WAIT_GAP) || (state_r == HELD);
  assign cnt_clr_s     = (state_next_s != state_r);

  // Compare target: last gap cycle in WAIT_GAP, one cycle ahead of the long-press length otherwise.
  always_comb begin
    cnt_target_s = long_len_s - CNT_TWO;
    if (state_r == WAIT_GAP) begin
      cnt_target_s = gap_s - CNT_ONE;
    end else begin
      cnt_target_s = long_len_s - CNT_TWO;
    end
  end

  pbutton_event_timer #(
    .W   (32),
    .SAT (CNT_MAX)
  ) u_cnt (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .target (cnt_target_s),
    .hit    (cnt_hit_s)
  );

`ifdef PBUTTON_AUTOREPEAT_EN
  localparam logic [REPEAT_W-1:0] RPT_ZERO = {REPEAT_W{1'b0}};
  localparam logic [REPEAT_W-1:0] RPT_ONE  = {{(REPEAT_W-1){1'b0}}, 1'b1};

  logic [REPEAT_W-1:0] rpt_target_s;
  logic                rpt_en_s;
  logic                rpt_clr_s;

  // Repeat compare value is R-1 with R clamped to at least 1.
  always_comb begin
    rpt_target_s = RPT_ZERO;
    if (bus.repeat_cycles == RPT_ZERO) begin
      rpt_target_s = RPT_ZERO;
    end else begin
      rpt_target_s = bus.repeat_cycles - RPT_ONE;
    end
  end

  // Runs only while held; restarts on HELD entry and after every repeat.
  assign rpt_en_s  = (state_r == HELD) && !released_s;
  assign rpt_clr_s = ((state_next_s == HELD) && (state_r != HELD)) ||
                     ((state_r == HELD) && rpt_hit_s);

  pbutton_event_timer #(
    .W   (REPEAT_W),
    .SAT ({REPEAT_W{1'b1}})
  ) u_rpt (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .clr    (rpt_clr_s),
    .en     (rpt_en_s),
    .target (rpt_target_s),
    .hit    (rpt_hit_s)
  );
`else
  assign rpt_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a release beats a simultaneous timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pushed_s) begin
          if (long_is_one_s) begin
            state_next_s = HELD;
          end else begin
            state_next_s = PRESSED;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESSED: begin
        if (released_s) begin
          if (gap_is_zero_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = WAIT_GAP;
          end
        end else if (cnt_hit_s) begin
          state_next_s = HELD;
        end else begin
          state_next_s = PRESSED;
        end
      end
      WAIT_GAP: begin
        if (pushed_s) begin
          state_next_s = SECOND;
        end else if (cnt_hit_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_GAP;
        end
      end
      SECOND: begin
        if (released_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SECOND;
        end
      end
      HELD: begin
        if (released_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HELD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Event decode for the next cycle's registered pulses.
  always_comb begin
    ev_click_s  = 1'b0;
    ev_double_s = 1'b0;
    ev_long_s   = 1'b0;
    ev_repeat_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pushed_s && long_is_one_s) begin
          ev_long_s = 1'b1;
        end else begin
          ev_long_s = 1'b0;
        end
      end
      PRESSED: begin
        if (released_s) begin
          ev_click_s = gap_is_zero_s;
        end else begin
          ev_long_s = cnt_hit_s;
        end
      end
      WAIT_GAP: begin
        if (pushed_s) begin
          ev_click_s = 1'b0;
        end else begin
          ev_click_s = cnt_hit_s;
        end
      end
      SECOND: begin
        ev_double_s = released_s;
      end
      HELD: begin
        ev_repeat_s = rpt_hit_s && !released_s;
      end
      default: begin
        ev_click_s = 1'b0;
      end
    endcase
  end

  // Event pulse registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ev_click_r  <= 1'b0;
      ev_double_r <= 1'b0;
      ev_long_r   <= 1'b0;
      ev_repeat_r <= 1'b0;
    end else begin
      ev_click_r  <= ev_click_s;
      ev_double_r <= ev_double_s;
      ev_long_r   <= ev_long_s;
      ev_repeat_r <= ev_repeat_s;
    end
  end

  // Running event count, one behind the pulses; preload wins over counting.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      event_count_r <= 16'd0;
    end else if (bus.count_load) begin
      event_count_r <= bus.count_load_value;
    end else if (ev_click_r || ev_double_r || ev_long_r || ev_repeat_r) begin
      event_count_r <= event_count_r + 16'd1;
    end else begin
      event_count_r <= event_count_r;
    end
  end

  assign bus.EV_click        = ev_click_r;
  assign bus.EV_double_click = ev_double_r;
  assign bus.EV_long_press   = ev_long_r;
  assign bus.EV_repeat       = ev_repeat_r;
  assign bus.event_count     = event_count_r;

endmodule

// File: tb/tb_pbutton_event_decoder.sv
// Self-checking bench for pbutton_event_decoder: directed cases followed by
// random press scenarios checked cycle by cycle against an event-level model.
module tb_pbutton_event_decoder;

  localparam int WMAX = 400;
`ifdef PBUTTON_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  obs    [WMAX];
  logic [3:0]  exp_ev [WMAX];
  logic [15:0] exp_total = 16'd0;

  pbutton_event_decoder_if #(.REPEAT_W(32)) bus ();

  pbutton_event_decoder #(.REPEAT_W(32)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic clear_exp();
    for (int c = 0; c < WMAX; c++) exp_ev[c] = 4'b0000;
  endtask

  // Event-level model. Bits: [0] click, [1] double, [2] long, [3] repeat.
  // Push at cycle 0, release at h; optional second push d cycles after the
  // release, held for h2 cycles.
  task automatic build_exp(input int lraw, input int g, input int rraw,
                           input int h, input int d, input int h2);
    int l;
    int r;
    l = (lraw < 1) ? 1 : lraw;
    r = (rraw < 1) ? 1 : rraw;
    clear_exp();
    if (h >= l) begin
      exp_ev[l][2] = 1'b1;
      if (AUTOREP) begin
        for (int t = l + r; t <= h; t += r) exp_ev[t][3] = 1'b1;
      end
    end else if (g == 0) begin
      exp_ev[h + 1][0] = 1'b1;
    end else if (d >= 1 && d <= g) begin
      exp_ev[h + d + h2 + 1][1] = 1'b1;
    end else begin
      exp_ev[h + g + 1][0] = 1'b1;
    end
  endtask

  // Drive one scenario; sample outputs then drive inputs on each falling edge.
  task automatic run_window(input int n, input int h, input int d, input int h2,
                            input bit both0, input int rst_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs[c] = {bus.EV_repeat, bus.EV_long_press, bus.EV_double_click, bus.EV_click};
      bus.PB_state_pushed   = (c == 0) || (d > 0 && c == h + d);
      bus.PB_state_released = (c == h) || (both0 && c == 0) || (d > 0 && c == h + d + h2);
      if (c == rst_at) rst = 1'b1;
      else if (c == rst_at + 2) rst = 1'b0;
    end
    @(negedge clk);
    bus.PB_state_pushed   = 1'b0;
    bus.PB_state_released = 1'b0;
  endtask

  task automatic compare_window(input string tag, input int n);
    int total;
    total = 0;
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s@%0d", tag, c), {28'd0, obs[c]}, {28'd0, exp_ev[c]});
      total += $countones(exp_ev[c]);
    end
    exp_total = exp_total + 16'(total);
    check({tag, ".count"}, {16'd0, bus.event_count}, {16'd0, exp_total});
  endtask

  initial begin
    int lraw, g, rraw, h, d, h2;
    bus.PB_state_pushed   = 1'b0;
    bus.PB_state_released = 1'b0;
    bus.long_press_cycles = 32'd100;
    bus.dbl_gap_cycles    = 32'd50;
    bus.repeat_cycles     = 32'd20;
    bus.count_load        = 1'b0;
    bus.count_load_value  = 16'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.ev", {28'd0, bus.EV_repeat, bus.EV_long_press, bus.EV_double_click, bus.EV_click}, 32'd0);
    check("reset.count", {16'd0, bus.event_count}, 32'd0);
    rst = 1'b0;

    // Short click: L=100, G=50, release at 10 -> click at 61.
    build_exp(100, 50, 20, 10, 0, 0);
    run_window(80, 10, 0, 0, 1'b0, -1);
    compare_window("click", 80);
    check("click.at61", {31'd0, obs[61][0]}, 32'd1);

    // Double click: release 10, push 30, release 40 -> double at 41.
    build_exp(100, 50, 20, 10, 20, 10);
    run_window(80, 10, 20, 10, 1'b0, -1);
    compare_window("double", 80);
    check("double.at41", {31'd0, obs[41][1]}, 32'd1);

    // Long press: L=100, release at 300 -> long at 100.
    build_exp(100, 50, 20, 300, 0, 0);
    run_window(320, 300, 0, 0, 1'b0, -1);
    compare_window("long", 320);
    check("long.at100", {31'd0, obs[100][2]}, 32'd1);

`ifdef PBUTTON_AUTOREPEAT_EN
    // Auto-repeat: L=100, R=20, release at 165 -> repeats at 120/140/160.
    build_exp(100, 50, 20, 165, 0, 0);
    run_window(200, 165, 0, 0, 1'b0, -1);
    compare_window("repeat", 200);
    check("repeat.at160", {31'd0, obs[160][3]}, 32'd1);
`endif

    // G=0: click one cycle after release.
    bus.dbl_gap_cycles = 32'd0;
    build_exp(100, 0, 20, 5, 0, 0);
    run_window(40, 5, 0, 0, 1'b0, -1);
    compare_window("gap0", 40);
    check("gap0.at6", {31'd0, obs[6][0]}, 32'd1);

    // L=0 behaves as L=1: long press one cycle after push.
    bus.long_press_cycles = 32'd0;
    bus.dbl_gap_cycles    = 32'd50;
    build_exp(0, 50, 20, 3, 0, 0);
    run_window(30, 3, 0, 0, 1'b0, -1);
    compare_window("long0", 30);
    check("long0.at1", {31'd0, obs[1][2]}, 32'd1);

    // Simultaneous push+release in IDLE, then a lone release: nothing happens.
    bus.long_press_cycles = 32'd100;
    bus.dbl_gap_cycles    = 32'd0;
    clear_exp();
    run_window(30, 5, 0, 0, 1'b1, -1);
    compare_window("simul", 30);

    // Reset during WAIT_GAP: no click, count back to 0.
    bus.dbl_gap_cycles = 32'd50;
    clear_exp();
    run_window(80, 10, 0, 0, 1'b0, 20);
    exp_total = 16'd0;
    compare_window("rstgap", 80);

    // Preload 0xFFFF, one click wraps the count to 0.
    @(negedge clk);
    bus.count_load       = 1'b1;
    bus.count_load_value = 16'hFFFF;
    @(negedge clk);
    bus.count_load = 1'b0;
    check("preload", {16'd0, bus.event_count}, 32'h0000_FFFF);
    exp_total = 16'hFFFF;
    bus.dbl_gap_cycles = 32'd0;
    build_exp(100, 0, 20, 4, 0, 0);
    run_window(20, 4, 0, 0, 1'b0, -1);
    compare_window("wrap", 20);
    check("wrap.zero", {16'd0, bus.event_count}, 32'd0);

    // Random scenarios.
    for (int i = 0; i < 30; i++) begin
      lraw = $urandom_range(0, 40);
      g    = $urandom_range(0, 20);
      rraw = $urandom_range(0, 8);
      h    = $urandom_range(1, 60);
      d    = 0;
      h2   = 0;
      if (h < ((lraw < 1) ? 1 : lraw) && g > 0 && $urandom_range(0, 1) == 1) begin
        d  = $urandom_range(1, g);
        h2 = $urandom_range(1, 10);
      end
      bus.long_press_cycles = 32'(lraw);
      bus.dbl_gap_cycles    = 32'(g);
      bus.repeat_cycles     = 32'(rraw);
      build_exp(lraw, g, rraw, h, d, h2);
      run_window(100, h, d, h2, 1'b0, -1);
      compare_window($sformatf("rnd%0d", i), 100);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
